// File: rtl/fifo_salida_demux.sv
// fifo_salida_demux
//   First-word-fall-through FIFO placed after one output of the 32-bit demux.
//   Buffers words until the consumer (memory write port / register write-back)
//   accepts them. Overflow and underflow are latched as sticky debug flags.
//
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset (pointers, count, sticky flags)
//   escribir      push request, qualifies dato_entrada
//   dato_entrada  word from the demux
//   leer          pop request from the consumer
//   dato_salida   head-of-queue word, 0 while empty
//   vacio         no valid entries
//   lleno         PROFUNDIDAD entries held
//   cuenta        occupancy, 0..PROFUNDIDAD
//   desborde      sticky: push dropped while full
//   subdesborde   sticky: pop requested while empty

module fifo_salida_demux #(
  parameter int unsigned ANCHO       = 32,
  parameter int unsigned PROFUNDIDAD = 4,
  parameter int unsigned PTR_W       = $clog2(PROFUNDIDAD)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             escribir,
  input  logic [ANCHO-1:0] dato_entrada,
  input  logic             leer,
  output logic [ANCHO-1:0] dato_salida,
  output logic             vacio,
  output logic             lleno,
  output logic [PTR_W:0]   cuenta,
  output logic             desborde,
  output logic             subdesborde
);

  localparam logic [PTR_W:0] CUENTA_LLENA = (PTR_W+1)'(PROFUNDIDAD);

  logic [ANCHO-1:0] mem_q [PROFUNDIDAD];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   cuenta_q, cuenta_d;
  logic             desborde_q, desborde_d;
  logic             subdesborde_q, subdesborde_d;

  logic push_ok;
  logic pop_ok;

  // Flags are decoded from the registered count only, so no input reaches them
  // combinationally.
  assign vacio = (cuenta_q == '0);
  assign lleno = (cuenta_q == CUENTA_LLENA);

  always_comb begin
    pop_ok        = leer && !vacio;
    // A full FIFO still accepts a push when a pop frees the head slot this cycle.
    push_ok       = escribir && (!lleno || pop_ok);
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    cuenta_d      = cuenta_q;
    desborde_d    = desborde_q;
    subdesborde_d = subdesborde_q;

    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;

    if (push_ok && !pop_ok)      cuenta_d = cuenta_q + 1'b1;
    else if (pop_ok && !push_ok) cuenta_d = cuenta_q - 1'b1;

    if (escribir && !push_ok) desborde_d    = 1'b1;
    if (leer && vacio)        subdesborde_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      cuenta_q      <= '0;
      desborde_q    <= 1'b0;
      subdesborde_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      cuenta_q      <= cuenta_d;
      desborde_q    <= desborde_d;
      subdesborde_q <= subdesborde_d;
    end
  end

  // Storage has no reset; stale contents are masked by vacio at the output.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem_q[wr_ptr_q] <= dato_entrada;
  end

  assign dato_salida = vacio ? '0 : mem_q[rd_ptr_q];
  assign cuenta      = cuenta_q;
  assign desborde    = desborde_q;
  assign subdesborde = subdesborde_q;

endmodule

// File: tb/tb_fifo_salida_demux.sv
module tb_fifo_salida_demux;

  logic        clk = 1'b0;
  logic        rst_n, escribir, leer;
  logic [31:0] dato_entrada, dato_salida;
  logic        vacio, lleno, desborde, subdesborde;
  logic [2:0]  cuenta;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;

  always #5 clk = ~clk;

  fifo_salida_demux #(.ANCHO(32), .PROFUNDIDAD(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .escribir     (escribir),
    .dato_entrada (dato_entrada),
    .leer         (leer),
    .dato_salida  (dato_salida),
    .vacio        (vacio),
    .lleno        (lleno),
    .cuenta       (cuenta),
    .desborde     (desborde),
    .subdesborde  (subdesborde)
  );

  typedef struct packed {
    logic        rst_n;
    logic        esc;
    logic        leer;
    logic [31:0] din;
    logic        v;
    logic        l;
    logic [2:0]  c;
    logic [31:0] d;
    logic        ds;
    logic        sd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, e, rd, input logic [31:0] din,
                     input logic v, l, input logic [2:0] c,
                     input logic [31:0] d, input logic ds, sd);
    vec_t x;
    x = '{rst_n: r, esc: e, leer: rd, din: din, v: v, l: l, c: c, d: d, ds: ds, sd: sd};
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic v, l, input logic [2:0] c,
                     input logic [31:0] d, input logic ds, sd);
    n_total++;
    if ({vacio, lleno, cuenta, dato_salida, desborde, subdesborde} === {v, l, c, d, ds, sd})
      n_pass++;
    else
      $display("FAIL %s: got vacio=%b lleno=%b cuenta=%0d dato=%h desb=%b subd=%b, want vacio=%b lleno=%b cuenta=%0d dato=%h desb=%b subd=%b",
               name, vacio, lleno, cuenta, dato_salida, desborde, subdesborde, v, l, c, d, ds, sd);
  endtask

  task automatic drive(input logic r, e, rd, input logic [31:0] din);
    @(negedge clk);
    rst_n = r; escribir = e; leer = rd; dato_entrada = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; escribir = 1'b0; leer = 1'b0; dato_entrada = '0;

    //   rst esc leer din           v  l  c  dato          ds sd
    add(0, 0, 0, 32'h0,           1, 0, 0, 32'h0,        0, 0); // reset state
    // single push, 1-cycle latency
    add(1, 1, 0, 32'hDEADBEEF,    0, 0, 1, 32'hDEADBEEF, 0, 0);
    add(1, 0, 1, 32'h0,           1, 0, 0, 32'h0,        0, 0);
    // fill with 1..4
    add(1, 1, 0, 32'h1,           0, 0, 1, 32'h1,        0, 0);
    add(1, 1, 0, 32'h2,           0, 0, 2, 32'h1,        0, 0);
    add(1, 1, 0, 32'h3,           0, 0, 3, 32'h1,        0, 0);
    add(1, 1, 0, 32'h4,           0, 1, 4, 32'h1,        0, 0);
    // overflow: 0x5 dropped
    add(1, 1, 0, 32'h5,           0, 1, 4, 32'h1,        1, 0);
    // drain in order
    add(1, 0, 1, 32'h0,           0, 0, 3, 32'h2,        1, 0);
    add(1, 0, 1, 32'h0,           0, 0, 2, 32'h3,        1, 0);
    add(1, 0, 1, 32'h0,           0, 0, 1, 32'h4,        1, 0);
    add(1, 0, 1, 32'h0,           1, 0, 0, 32'h0,        1, 0);
    // refill, then push+pop while full, crossing pointer wrap
    add(1, 1, 0, 32'h11,          0, 0, 1, 32'h11,       1, 0);
    add(1, 1, 0, 32'h12,          0, 0, 2, 32'h11,       1, 0);
    add(1, 1, 0, 32'h13,          0, 0, 3, 32'h11,       1, 0);
    add(1, 1, 0, 32'h14,          0, 1, 4, 32'h11,       1, 0);
    add(1, 1, 1, 32'hA,           0, 1, 4, 32'h12,       1, 0);
    add(1, 1, 1, 32'hB,           0, 1, 4, 32'h13,       1, 0);
    add(1, 1, 1, 32'hC,           0, 1, 4, 32'h14,       1, 0);
    add(1, 1, 1, 32'hD,           0, 1, 4, 32'hA,        1, 0);
    add(1, 0, 1, 32'h0,           0, 0, 3, 32'hB,        1, 0);
    add(1, 0, 1, 32'h0,           0, 0, 2, 32'hC,        1, 0);
    add(1, 0, 1, 32'h0,           0, 0, 1, 32'hD,        1, 0);
    add(1, 0, 1, 32'h0,           1, 0, 0, 32'h0,        1, 0);
    // underflow with simultaneous push
    add(1, 1, 1, 32'h77,          0, 0, 1, 32'h77,       1, 1);
    // push+pop with one entry held
    add(1, 1, 1, 32'h21,          0, 0, 1, 32'h21,       1, 1);
    add(1, 1, 0, 32'h22,          0, 0, 2, 32'h21,       1, 1);
    add(1, 1, 0, 32'h23,          0, 0, 3, 32'h21,       1, 1);
    // reset with 3 entries, push requested: reset wins
    add(0, 1, 0, 32'h99,          1, 0, 0, 32'h0,        0, 0);
    // pop on empty alone
    add(1, 0, 1, 32'h0,           1, 0, 0, 32'h0,        0, 1);
    add(0, 0, 0, 32'h0,           1, 0, 0, 32'h0,        0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].esc, vecs[i].leer, vecs[i].din);
      chk($sformatf("vec%0d", i), vecs[i].v, vecs[i].l, vecs[i].c, vecs[i].d,
          vecs[i].ds, vecs[i].sd);
    end

    // No same-cycle bypass: a push request must not show before the edge.
    @(negedge clk);
    rst_n = 1'b1; escribir = 1'b1; leer = 1'b0; dato_entrada = 32'hCAFE0001;
    #1;
    chk("no_bypass_pre_edge", 1, 0, 0, 32'h0, 0, 0);
    @(posedge clk); #1;
    chk("no_bypass_post_edge", 0, 0, 1, 32'hCAFE0001, 0, 0);

    // Fill, then hammer with dropped pushes for several cycles.
    for (int i = 2; i <= 4; i++) begin
      drive(1, 1, 0, 32'hCAFE0000 + 32'(i));
    end
    chk("fill_full", 0, 1, 4, 32'hCAFE0001, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 32'hBAD00000 + 32'(i));
      chk($sformatf("drop%0d", i), 0, 1, 4, 32'hCAFE0001, 1, 0);
    end
    // Drain: dropped words must never appear.
    for (int i = 2; i <= 4; i++) begin
      drive(1, 0, 1, 32'h0);
      chk($sformatf("drain%0d", i), 0, 0, 3'(5 - i), 32'hCAFE0000 + 32'(i), 1, 0);
    end
    drive(1, 0, 1, 32'h0);
    chk("drain_empty", 1, 0, 0, 32'h0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
